regf_arb_ctrl: RTL and testbench

Controller that initialises and shares one 4x8 register file (1 write port, 1 combinational read port, write on the clock edge when `wr_e` is high) between two requesters. After reset it clears all four registers. It then grants one read or write transaction per cycle, using round-robin arbitration. It sits between the requesters and the register file and drives every register-file input.

---
 rtl/regf_arb_ctrl.sv | 171 +++++++++++++++++
 tb/tb_regf_arb_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regf_arb_ctrl.sv
// regf_arb_ctrl: clears a 4x8 register file after reset, then shares it
// between two requesters with one granted read or write per cycle.
// Grants are round-robin. Read responses are registered; writes complete
// at the grant edge.
module regf_arb_ctrl (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [1:0] addr0,
  input  logic [1:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       init_done,
  output logic       rf_wr_e,
  output logic [1:0] rf_wr_addr,
  output logic [7:0] rf_wr_data,
  output logic [1:0] rf_rd_addr,
  input  logic [7:0] rf_rd_data
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [1:0] cnt_r;
  logic       prio_r;
  logic       init_done_r;
  logic       rvalid0_r;
  logic       rvalid1_r;
  logic [7:0] rdata0_r;
  logic [7:0] rdata1_r;

  logic       gnt0_s;
  logic       gnt1_s;
  logic       rf_wr_e_s;
  logic [1:0] rf_wr_addr_s;
  logic [7:0] rf_wr_data_s;
  logic [1:0] rf_rd_addr_s;
  logic       rd_xfer0_s;
  logic       rd_xfer1_s;

  // Grant selection, register-file drive and next-state decision.
  always_comb begin
    state_next_s = state_r;
    gnt0_s       = 1'b0;
    gnt1_s       = 1'b0;
    rf_wr_e_s    = 1'b0;
    rf_wr_addr_s = addr0;
    rf_wr_data_s = wdata0;
    rf_rd_addr_s = addr0;
    case (state_r)
      ST_INIT: begin
        // Clear one register per cycle; nothing is granted yet.
        rf_wr_e_s    = 1'b1;
        rf_wr_addr_s = cnt_r;
        rf_wr_data_s = 8'h00;
        rf_rd_addr_s = 2'd0;
        if (cnt_r == 2'd3) begin
          state_next_s = ST_ARB;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_ARB: begin
        // Requester 0 wins when alone or when it holds priority.
        if (req0 && (!req1 || !prio_r)) begin
          gnt0_s    = 1'b1;
          rf_wr_e_s = we0;
        end else if (req1) begin
          gnt1_s       = 1'b1;
          rf_wr_e_s    = we1;
          rf_wr_addr_s = addr1;
          rf_wr_data_s = wdata1;
          rf_rd_addr_s = addr1;
        end else begin
          rf_wr_e_s = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_INIT;
      end
    endcase
  end

  // A read transfer is a grant to a requester that is not writing.
  always_comb begin
    rd_xfer0_s = gnt0_s & ~we0;
    rd_xfer1_s = gnt1_s & ~we1;
  end

  // Control state: phase, clear counter, completion flag and priority.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r     <= ST_INIT;
      cnt_r       <= 2'd0;
      prio_r      <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        ST_INIT: begin
          cnt_r <= cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            init_done_r <= 1'b1;
          end else begin
            init_done_r <= 1'b0;
          end
        end
        ST_ARB: begin
          // Priority passes to whichever requester lost (or was absent).
          if (gnt0_s) begin
            prio_r <= 1'b1;
          end else if (gnt1_s) begin
            prio_r <= 1'b0;
          end else begin
            prio_r <= prio_r;
          end
        end
        default: begin
          cnt_r       <= 2'd0;
          prio_r      <= 1'b0;
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Read responses: one-cycle valid pulse, data held until the next read.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= 8'h00;
      rdata1_r  <= 8'h00;
    end else begin
      rvalid0_r <= rd_xfer0_s;
      rvalid1_r <= rd_xfer1_s;
      if (rd_xfer0_s) begin
        rdata0_r <= rf_rd_data;
      end
      if (rd_xfer1_s) begin
        rdata1_r <= rf_rd_data;
      end
    end
  end

  assign gnt0       = gnt0_s;
  assign gnt1       = gnt1_s;
  assign rvalid0    = rvalid0_r;
  assign rvalid1    = rvalid1_r;
  assign rdata0     = rdata0_r;
  assign rdata1     = rdata1_r;
  assign init_done  = init_done_r;
  assign rf_wr_e    = rf_wr_e_s;
  assign rf_wr_addr = rf_wr_addr_s;
  assign rf_wr_data = rf_wr_data_s;
  assign rf_rd_addr = rf_rd_addr_s;

endmodule

// File: tb/tb_regf_arb_ctrl.sv
// Testbench for regf_arb_ctrl: a 4x8 register file model in the
// environment, a transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_regf_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [1:0] addr0 = 2'd0, addr1 = 2'd0;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic       gnt0, gnt1, rvalid0, rvalid1, init_done;
  logic [7:0] rdata0, rdata1;
  logic       rf_wr_e;
  logic [1:0] rf_wr_addr, rf_rd_addr;
  logic [7:0] rf_wr_data, rf_rd_data;

  int n_err = 0;
  int n_checks = 0;

  regf_arb_ctrl dut (
    .clk(clk), .rst_b(rst_b),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .init_done(init_done),
    .rf_wr_e(rf_wr_e), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
  );

  always #5 clk = ~clk;

  // Register file the controller drives; starts with non-zero junk.
  logic [7:0] rf_mem [4];
  initial begin
    for (int i = 0; i < 4; i++) rf_mem[i] = 8'hE0 + 8'(i);
  end
  always @(posedge clk) begin
    if (rf_wr_e) rf_mem[rf_wr_addr] <= rf_wr_data;
  end
  assign rf_rd_data = rf_mem[rf_rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles since reset, memory contents, priority, responses.
  int         m_cyc = 0;
  int         m_prio = 0;
  logic [7:0] m_mem [4];
  logic       m_rv [2];
  logic [7:0] m_rd [2];
  logic       r_in [2];
  logic       w_in [2];
  logic [1:0] a_in [2];
  logic [7:0] d_in [2];
  int         win;
  logic       e_we;
  logic [1:0] e_wa, e_ra;
  logic [7:0] e_wd;

  // Compare process: check DUT against the model, then advance the model.
  always @(negedge clk) begin
    if (!rst_b) begin
      m_cyc = 0; m_prio = 0;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_rvalid0", rvalid0, 0);
      check("rst_rvalid1", rvalid1, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_init_done", init_done, 0);
    end else begin
      r_in[0] = req0; r_in[1] = req1; w_in[0] = we0; w_in[1] = we1;
      a_in[0] = addr0; a_in[1] = addr1; d_in[0] = wdata0; d_in[1] = wdata1;
      win = -1;
      if (m_cyc < 4) begin
        e_we = 1'b1; e_wa = m_cyc[1:0]; e_wd = 8'h00; e_ra = 2'd0;
      end else begin
        if (r_in[0] && r_in[1]) win = m_prio;
        else if (r_in[0]) win = 0;
        else if (r_in[1]) win = 1;
        if (win >= 0) begin
          e_we = w_in[win]; e_wa = a_in[win]; e_wd = d_in[win]; e_ra = a_in[win];
        end else begin
          e_we = 1'b0; e_wa = addr0; e_wd = wdata0; e_ra = addr0;
        end
      end
      check("m_gnt0", gnt0, (win == 0) ? 1 : 0);
      check("m_gnt1", gnt1, (win == 1) ? 1 : 0);
      check("m_rf_wr_e", rf_wr_e, e_we);
      check("m_rf_wr_addr", rf_wr_addr, e_wa);
      check("m_rf_wr_data", rf_wr_data, e_wd);
      check("m_rf_rd_addr", rf_rd_addr, e_ra);
      check("m_init_done", init_done, (m_cyc >= 4) ? 1 : 0);
      check("m_rvalid0", rvalid0, m_rv[0]);
      check("m_rvalid1", rvalid1, m_rv[1]);
      check("m_rdata0", rdata0, m_rd[0]);
      check("m_rdata1", rdata1, m_rd[1]);
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      if (m_cyc < 4) begin
        m_mem[m_cyc] = 8'h00;
        m_cyc++;
      end else if (win >= 0) begin
        if (w_in[win]) m_mem[a_in[win]] = d_in[win];
        else begin
          m_rv[win] = 1'b1;
          m_rd[win] = m_mem[a_in[win]];
        end
        m_prio = 1 - win;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
  endtask

  int  exp_order [6] = '{0, 1, 0, 1, 0, 1};
  logic took0, took1;

  initial begin
    // Clear sequence, then a read of a cleared register.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("clr_we", rf_wr_e, 1);
      check("clr_addr", rf_wr_addr, i);
      check("clr_data", rf_wr_data, 8'h00);
      check("clr_done", init_done, 0);
      step();
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd3;
    @(negedge clk);
    check("init_done_hi", init_done, 1);
    check("first_gnt0", gnt0, 1);
    step(); req0 = 1'b0;
    @(negedge clk);
    check("clr_rvalid0", rvalid0, 1);
    check("clr_rdata0", rdata0, 8'h00);

    // Simultaneous writes to the same address with priority on requester 0.
    step(); req1 = 1'b1; we1 = 1'b0; addr1 = 2'd0;
    @(negedge clk); check("pre_gnt1", gnt1, 1);
    step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'hA5;
    req1 = 1'b1; we1 = 1'b1; addr1 = 2'd1; wdata1 = 8'h3C;
    @(negedge clk); check("sim_gnt0", gnt0, 1); check("sim_not_gnt1", gnt1, 0);
    step(); req0 = 1'b0;
    @(negedge clk); check("sim_gnt1", gnt1, 1);
    step(); req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 2'd1;
    @(negedge clk); check("sim_rd_gnt0", gnt0, 1);
    step(); req0 = 1'b0;
    @(negedge clk);
    check("sim_rvalid0", rvalid0, 1);
    check("sim_rdata0", rdata0, 8'h3C);

    // Round-robin with both requesters reading continuously.
    step(); req1 = 1'b1; we1 = 1'b0; addr1 = 2'd0;
    @(negedge clk);
    step(); req0 = 1'b1; we0 = 1'b0; addr0 = 2'd1; addr1 = 2'd2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_gnt0", gnt0, (exp_order[k] == 0) ? 1 : 0);
      check("rr_gnt1", gnt1, (exp_order[k] == 1) ? 1 : 0);
      if (k > 0) begin
        check("rr_rvalid0", rvalid0, (exp_order[k-1] == 0) ? 1 : 0);
        check("rr_rvalid1", rvalid1, (exp_order[k-1] == 1) ? 1 : 0);
      end
      step();
    end

    // Write then read back by requester 1.
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 2'd2; wdata1 = 8'h5A;
    @(negedge clk); check("wr_gnt1", gnt1, 1);
    step(); we1 = 1'b0;
    @(negedge clk); check("rd_gnt1", gnt1, 1);
    step(); req1 = 1'b0;
    @(negedge clk);
    check("wr_rd_rdata1", rdata1, 8'h5A);
    check("wr_rd_rvalid1", rvalid1, 1);
    check("wr_rd_rdata0_kept", rdata0, 8'h3C);
    step();
    @(negedge clk); check("rvalid1_pulse_end", rvalid1, 0);

    // Reset asserted while a read is being granted.
    step(); req0 = 1'b1; we0 = 1'b0; addr0 = 2'd1;
    @(negedge clk); check("mid_gnt0", gnt0, 1);
    #1 rst_b = 1'b0;
    #1;
    check("mid_rst_gnt0", gnt0, 0);
    check("mid_rst_gnt1", gnt1, 0);
    check("mid_rst_rvalid0", rvalid0, 0);
    check("mid_rst_rdata0", rdata0, 8'h00);
    check("mid_rst_rdata1", rdata1, 8'h00);
    check("mid_rst_done", init_done, 0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd3;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("re_clr_addr", rf_wr_addr, i);
      check("re_clr_gnt0", gnt0, 0);
      step();
    end
    @(negedge clk);
    check("re_prio_gnt0", gnt0, 1);
    check("re_init_done", init_done, 1);
    step(); req0 = 1'b0; req1 = 1'b0;

    // Random traffic; each requester holds its fields until granted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      took0 = req0 & gnt0;
      took1 = req1 & gnt1;
      step();
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        if (took0 || !req0) begin
          req0 = ($urandom_range(0, 3) != 0);
          we0 = 1'($urandom_range(0, 1));
          addr0 = 2'($urandom_range(0, 3));
          wdata0 = 8'($urandom);
        end
        if (took1 || !req1) begin
          req1 = ($urandom_range(0, 3) != 0);
          we1 = 1'($urandom_range(0, 1));
          addr1 = 2'($urandom_range(0, 3));
          wdata1 = 8'($urandom);
        end
      end
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
